fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Y86-64 pipeline fetch stage. It sits between the F pipeline register (source of F_predPC) and the D pipeline register.
- Selects the fetch PC from the predicted PC, a mispredicted-branch fall-through, or a ret target.
- Issues a request/acknowledge read of a 10-byte instruction window to instruction memory and decodes the instruction fields.
- Holds the result in registered outputs until decode accepts it.
- Produces the next predicted PC and a stall request for the hazard unit while memory is outstanding.

Parameters:
ADDR_W, 64, PC / address width
WIN_BYTES, 10, instruction window bytes returned per read (max Y86 instruction length)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
F_predPC_i  in  ADDR_W  predicted PC from F register
M_icode_i  in  4  memory-stage icode
M_Cnd_i  in  1  memory-stage branch condition
M_valA_i  in  ADDR_W  fall-through PC of mispredicted jXX
W_icode_i  in  4  write-back icode
W_valM_i  in  ADDR_W  ret target
D_stall_i  in  1  decode register not accepting
imem_req_o  out  1  read request
imem_addr_o  out  ADDR_W  read address
imem_ack_i  in  1  read data valid
imem_rdata_i  in  8*WIN_BYTES  bytes, byte0 at [7:0], little-endian
imem_err_i  in  1  address error, qualified by ack
f_valid_o  out  1  decoded outputs valid
f_icode_o  out  4  icode
f_ifun_o  out  4  ifun
f_rA_o  out  4  rA (0xF if no regids)
f_rB_o  out  4  rB (0xF if no regids)
f_valC_o  out  64  constant (0 if none)
f_valP_o  out  ADDR_W  next sequential PC
f_predPC_o  out  ADDR_W  predicted next PC, to F register
f_stat_o  out  2  1 AOK, 2 HLT, 3 ADR, 4 INS (as 3-bit value 4 mapped to encoding 0)
f_stall_req_o  out  1  to hazard unit; F must stall

Behaviour:
- Reset (async): state IDLE, imem_req_o=0, f_valid_o=0, all data outputs 0, f_stat_o=AOK, f_stall_req_o=1.
- PC select (combinational):
  - redirect=1 and pc=M_valA_i if M_icode_i==JXX(7) && !M_Cnd_i.
  - Else redirect=1 and pc=W_valM_i if W_icode_i==RET(9).
  - Else pc=F_predPC_i, redirect=0.
- FSM states: IDLE, REQ, DRAIN, HOLD.
  - IDLE: next cycle -> REQ; latch req_pc=pc; imem_addr_o=req_pc; imem_req_o=1.
  - REQ: req held high until ack.
    - ack && !redirect -> capture decoded fields into outputs, f_valid_o=1, -> HOLD.
    - ack && redirect -> discard data, -> IDLE.
    - !ack && redirect -> DRAIN.
  - DRAIN: req held; on ack, discard data -> IDLE.
  - HOLD: outputs stable while D_stall_i.
    - !D_stall_i -> f_valid_o=0, -> IDLE.
    - redirect in HOLD -> drop (f_valid_o=0), -> IDLE.
- Redirect priority: redirect beats ack in the same cycle.
- f_stall_req_o=1 in every state except HOLD with !D_stall_i. F_predPC advances exactly once per accepted instruction.
- Decode rules (on captured window):
  - icode=b0[7:4], ifun=b0[3:0].
  - need_regids for icode in {2,3,4,5,6,A,B}: rA=b1[7:4], rB=b1[3:0].
  - need_valC for icode in {3,4,5,7,8}: valC = 8 bytes starting at byte 1+need_regids.
  - valP = req_pc + 1 + need_regids + 8*need_valC, modulo 2^ADDR_W.
  - predPC = valC for icode 7,8; else valP.
  - Illegal icode (>0xB) -> stat INS, icode forced NOP.
  - imem_err_i -> stat ADR, icode forced NOP.
  - icode 0 -> HLT.
  - ADR takes priority over INS.
- Once f_stat_o≠AOK is captured, fetching stops. The block stays in HOLD/IDLE without requesting until reset or redirect.
- Latency: minimum 3 cycles per instruction (IDLE, REQ with ack, HOLD accept) plus memory wait cycles.

Test Plan:
- F_predPC=0x0, window starts 30 F2 0A 00 00 00 00 00 00 00 (irmovq $10,%rdx), ack after 2 cycles -> f_icode=3, rB=2, valC=0xA, valP=0xA, predPC=0xA, stat AOK, f_valid_o=1.
- jmp at 0x20 to 0x100 (70 00 01 00..) -> predPC=0x100, valP=0x29, rA=rB=0xF.
- D_stall_i held 4 cycles in HOLD -> outputs unchanged, f_stall_req_o=1, no new imem_req_o; deassert -> next request issues at the following PC.
- M_icode=7, M_Cnd=0, M_valA=0x40 while a request is in REQ with ack 3 cycles later -> DRAIN, data discarded, next imem_addr_o=0x40. Same test with ack in the redirect cycle -> data discarded, no f_valid_o pulse.
- Byte0=0xC0 -> stat INS, icode=1. ack with imem_err_i=1 -> stat ADR. No further requests in either case.
- Assert rst_i mid-REQ -> imem_req_o and f_valid_o drop to 0 without a clock edge; fetch restarts from IDLE after release.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Y86-64 pipeline fetch stage, between the F pipeline register and the D
// pipeline register. Each instruction is fetched with one request/acknowledge
// read of a WIN_BYTES window from instruction memory. The window is decoded
// and the result is held in registered outputs until decode accepts it.
//
// Handshakes:
//   imem_req_o / imem_ack_i : imem_req_o rises with a stable imem_addr_o and
//     stays high until the cycle in which imem_ack_i is sampled high. That
//     cycle carries imem_rdata_i / imem_err_i. The request drops the next
//     cycle. ack is only looked at while a request is outstanding.
//   f_valid_o / D_stall_i   : f_valid_o high means the f_* fields hold one
//     decoded instruction. It is consumed on a clock edge where
//     D_stall_i is low. The fields stay stable while D_stall_i is high.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   F_predPC_i            predicted PC from the F register
//   M_icode_i, M_Cnd_i,
//   M_valA_i              mispredicted jXX detection and fall-through PC
//   W_icode_i, W_valM_i   ret detection and return target
//   D_stall_i             decode register not accepting
//   imem_req_o,
//   imem_addr_o           instruction memory read request and address
//   imem_ack_i,
//   imem_rdata_i,
//   imem_err_i            read data valid, window (byte0 at [7:0]),
//                         and address error
//   f_valid_o ... f_stat_o decoded instruction (registered)
//   f_predPC_o            predicted next PC, to the F register
//   f_stall_req_o         to the hazard unit. F must hold its PC.
//
// Status encoding on f_stat_o: 1 AOK, 2 HLT, 3 ADR, 0 INS.
// WIN_BYTES must be at least 10.
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int ADDR_W    = 64,
   parameter int WIN_BYTES = 10
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [ADDR_W-1:0]      F_predPC_i,
   input  logic [3:0]             M_icode_i,
   input  logic                   M_Cnd_i,
   input  logic [ADDR_W-1:0]      M_valA_i,
   input  logic [3:0]             W_icode_i,
   input  logic [ADDR_W-1:0]      W_valM_i,
   input  logic                   D_stall_i,
   output logic                   imem_req_o,
   output logic [ADDR_W-1:0]      imem_addr_o,
   input  logic                   imem_ack_i,
   input  logic [8*WIN_BYTES-1:0] imem_rdata_i,
   input  logic                   imem_err_i,
   output logic                   f_valid_o,
   output logic [3:0]             f_icode_o,
   output logic [3:0]             f_ifun_o,
   output logic [3:0]             f_rA_o,
   output logic [3:0]             f_rB_o,
   output logic [63:0]            f_valC_o,
   output logic [ADDR_W-1:0]      f_valP_o,
   output logic [ADDR_W-1:0]      f_predPC_o,
   output logic [1:0]             f_stat_o,
   output logic                   f_stall_req_o
);

   localparam logic [3:0] I_HALT = 4'h0;
   localparam logic [3:0] I_NOP  = 4'h1;
   localparam logic [3:0] I_JXX  = 4'h7;
   localparam logic [3:0] I_CALL = 4'h8;
   localparam logic [3:0] I_RET  = 4'h9;
   localparam logic [3:0] I_MAX  = 4'hB;

   localparam logic [1:0] STAT_INS = 2'd0;
   localparam logic [1:0] STAT_AOK = 2'd1;
   localparam logic [1:0] STAT_HLT = 2'd2;
   localparam logic [1:0] STAT_ADR = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DRAIN = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
   logic                req_q, req_d;
   logic                valid_q, valid_d;
   logic [3:0]          icode_q, icode_d;
   logic [3:0]          ifun_q, ifun_d;
   logic [3:0]          ra_q, ra_d;
   logic [3:0]          rb_q, rb_d;
   logic [63:0]         valc_q, valc_d;
   logic [ADDR_W-1:0]   valp_q, valp_d;
   logic [ADDR_W-1:0]   pred_q, pred_d;
   logic [1:0]          stat_q, stat_d;
   // Set once a non-AOK status has been captured. Fetch stays parked until
   // a redirect arrives or reset.
   logic                halted_q, halted_d;
   // A redirect seen while the fetch could not act on it immediately (request
   // in flight, or instruction held). It is remembered so the next request
   // goes to the redirect target even if the M/W stages have moved on.
   logic                redir_pend_q, redir_pend_d;
   logic [ADDR_W-1:0]   redir_pc_q, redir_pc_d;

   // ---------------------------------------------------------------------
   // PC select
   // ---------------------------------------------------------------------
   logic                redirect;
   logic [ADDR_W-1:0]   redirect_pc;
   logic [ADDR_W-1:0]   fetch_pc;

   always_comb begin
      redirect    = 1'b0;
      redirect_pc = '0;
      if (M_icode_i == I_JXX && !M_Cnd_i) begin
         redirect    = 1'b1;
         redirect_pc = M_valA_i;
      end else if (W_icode_i == I_RET) begin
         redirect    = 1'b1;
         redirect_pc = W_valM_i;
      end
   end

   // A live redirect is newer than a remembered one, so it wins.
   always_comb begin
      if (redirect) begin
         fetch_pc = redirect_pc;
      end else if (redir_pend_q) begin
         fetch_pc = redir_pc_q;
      end else begin
         fetch_pc = F_predPC_i;
      end
   end

   // ---------------------------------------------------------------------
   // Decode of the returned window (only used in the ack cycle)
   // ---------------------------------------------------------------------
   logic [3:0]          raw_icode;
   logic [3:0]          dec_icode;
   logic [3:0]          dec_ifun;
   logic [3:0]          dec_ra;
   logic [3:0]          dec_rb;
   logic [63:0]         dec_valc;
   logic [ADDR_W-1:0]   dec_valp;
   logic [ADDR_W-1:0]   dec_pred;
   logic [1:0]          dec_stat;
   logic                need_regids;
   logic                need_valc;
   logic [3:0]          inst_len;

   always_comb begin
      raw_icode = imem_rdata_i[7:4];
      dec_icode = raw_icode;
      dec_ifun  = imem_rdata_i[3:0];
      dec_stat  = STAT_AOK;
      // An address error makes the bytes meaningless, so it outranks the
      // illegal-opcode check. Both turn the instruction into a clean nop.
      if (imem_err_i) begin
         dec_icode = I_NOP;
         dec_ifun  = 4'h0;
         dec_stat  = STAT_ADR;
      end else if (raw_icode > I_MAX) begin
         dec_icode = I_NOP;
         dec_ifun  = 4'h0;
         dec_stat  = STAT_INS;
      end else if (raw_icode == I_HALT) begin
         dec_stat  = STAT_HLT;
      end

      case (dec_icode)
         4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
         default:                                  need_regids = 1'b0;
      endcase

      case (dec_icode)
         4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc = 1'b1;
         default:                      need_valc = 1'b0;
      endcase

      dec_ra = 4'hF;
      dec_rb = 4'hF;
      if (need_regids) begin
         dec_ra = imem_rdata_i[15:12];
         dec_rb = imem_rdata_i[11:8];
      end

      // The constant starts right after the register byte when there is one.
      dec_valc = 64'd0;
      if (need_valc) begin
         if (need_regids) begin
            dec_valc = imem_rdata_i[16 +: 64];
         end else begin
            dec_valc = imem_rdata_i[8 +: 64];
         end
      end

      inst_len = 4'd1 + {3'd0, need_regids} + (need_valc ? 4'd8 : 4'd0);
      dec_valp = req_pc_q + ADDR_W'(inst_len);

      if (dec_icode == I_JXX || dec_icode == I_CALL) begin
         dec_pred = ADDR_W'(dec_valc);
      end else begin
         dec_pred = dec_valp;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and register updates
   // ---------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      req_pc_d     = req_pc_q;
      req_d        = req_q;
      valid_d      = valid_q;
      icode_d      = icode_q;
      ifun_d       = ifun_q;
      ra_d         = ra_q;
      rb_d         = rb_q;
      valc_d       = valc_q;
      valp_d       = valp_q;
      pred_d       = pred_q;
      stat_d       = stat_q;
      halted_d     = halted_q;
      redir_pend_d = redir_pend_q;
      redir_pc_d   = redir_pc_q;

      case (state_q)
         S_IDLE: begin
            // A parked (halted) fetch only restarts on a redirect.
            if (!halted_q || redirect || redir_pend_q) begin
               state_d      = S_REQ;
               req_pc_d     = fetch_pc;
               req_d        = 1'b1;
               halted_d     = 1'b0;
               redir_pend_d = 1'b0;
            end
         end

         S_REQ: begin
            // Redirect beats ack: the returned window belongs to a squashed
            // path and is thrown away.
            if (redirect) begin
               redir_pend_d = 1'b1;
               redir_pc_d   = redirect_pc;
               if (imem_ack_i) begin
                  req_d   = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DRAIN;
               end
            end else if (imem_ack_i) begin
               req_d    = 1'b0;
               valid_d  = 1'b1;
               icode_d  = dec_icode;
               ifun_d   = dec_ifun;
               ra_d     = dec_ra;
               rb_d     = dec_rb;
               valc_d   = dec_valc;
               valp_d   = dec_valp;
               pred_d   = dec_pred;
               stat_d   = dec_stat;
               halted_d = (dec_stat != STAT_AOK);
               state_d  = S_HOLD;
            end
         end

         S_DRAIN: begin
            // The outstanding read must complete before a new one is issued.
            if (redirect) begin
               redir_pend_d = 1'b1;
               redir_pc_d   = redirect_pc;
            end
            if (imem_ack_i) begin
               req_d   = 1'b0;
               state_d = S_IDLE;
            end
         end

         S_HOLD: begin
            if (redirect) begin
               redir_pend_d = 1'b1;
               redir_pc_d   = redirect_pc;
               valid_d      = 1'b0;
               state_d      = S_IDLE;
            end else if (!D_stall_i) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         req_pc_q     <= '0;
         req_q        <= 1'b0;
         valid_q      <= 1'b0;
         icode_q      <= 4'h0;
         ifun_q       <= 4'h0;
         ra_q         <= 4'h0;
         rb_q         <= 4'h0;
         valc_q       <= 64'd0;
         valp_q       <= '0;
         pred_q       <= '0;
         stat_q       <= STAT_AOK;
         halted_q     <= 1'b0;
         redir_pend_q <= 1'b0;
         redir_pc_q   <= '0;
      end else begin
         state_q      <= state_d;
         req_pc_q     <= req_pc_d;
         req_q        <= req_d;
         valid_q      <= valid_d;
         icode_q      <= icode_d;
         ifun_q       <= ifun_d;
         ra_q         <= ra_d;
         rb_q         <= rb_d;
         valc_q       <= valc_d;
         valp_q       <= valp_d;
         pred_q       <= pred_d;
         stat_q       <= stat_d;
         halted_q     <= halted_d;
         redir_pend_q <= redir_pend_d;
         redir_pc_q   <= redir_pc_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign imem_req_o  = req_q;
   assign imem_addr_o = req_pc_q;
   assign f_valid_o   = valid_q;
   assign f_icode_o   = icode_q;
   assign f_ifun_o    = ifun_q;
   assign f_rA_o      = ra_q;
   assign f_rB_o      = rb_q;
   assign f_valC_o    = valc_q;
   assign f_valP_o    = valp_q;
   assign f_predPC_o  = pred_q;
   assign f_stat_o    = stat_q;

   // F may only advance in the cycle decode takes the held instruction, so
   // the predicted PC moves exactly once per accepted instruction.
   assign f_stall_req_o = !(state_q == S_HOLD && !D_stall_i);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam int ADDR_W    = 64;
   localparam int WIN_BYTES = 10;
   localparam int WIN_W     = 8 * WIN_BYTES;

   localparam logic [1:0] ST_INS = 2'd0;
   localparam logic [1:0] ST_AOK = 2'd1;
   localparam logic [1:0] ST_HLT = 2'd2;
   localparam logic [1:0] ST_ADR = 2'd3;

   typedef struct packed {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [63:0] valc;
      logic [63:0] valp;
      logic [63:0] pred;
      logic [1:0]  stat;
   } exp_t;

   localparam int EXP_W = $bits(exp_t);

   // ---------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------
   logic              clk_i;
   logic              rst_i;
   logic [ADDR_W-1:0] F_predPC_i;
   logic [3:0]        M_icode_i;
   logic              M_Cnd_i;
   logic [ADDR_W-1:0] M_valA_i;
   logic [3:0]        W_icode_i;
   logic [ADDR_W-1:0] W_valM_i;
   logic              D_stall_i;
   logic              imem_req_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic              imem_ack_i;
   logic [WIN_W-1:0]  imem_rdata_i;
   logic              imem_err_i;
   logic              f_valid_o;
   logic [3:0]        f_icode_o;
   logic [3:0]        f_ifun_o;
   logic [3:0]        f_rA_o;
   logic [3:0]        f_rB_o;
   logic [63:0]       f_valC_o;
   logic [ADDR_W-1:0] f_valP_o;
   logic [ADDR_W-1:0] f_predPC_o;
   logic [1:0]        f_stat_o;
   logic              f_stall_req_o;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   fetch_stage #(.ADDR_W(ADDR_W), .WIN_BYTES(WIN_BYTES)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .F_predPC_i    (F_predPC_i),
      .M_icode_i     (M_icode_i),
      .M_Cnd_i       (M_Cnd_i),
      .M_valA_i      (M_valA_i),
      .W_icode_i     (W_icode_i),
      .W_valM_i      (W_valM_i),
      .D_stall_i     (D_stall_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_rdata_i  (imem_rdata_i),
      .imem_err_i    (imem_err_i),
      .f_valid_o     (f_valid_o),
      .f_icode_o     (f_icode_o),
      .f_ifun_o      (f_ifun_o),
      .f_rA_o        (f_rA_o),
      .f_rB_o        (f_rB_o),
      .f_valC_o      (f_valC_o),
      .f_valP_o      (f_valP_o),
      .f_predPC_o    (f_predPC_o),
      .f_stat_o      (f_stat_o),
      .f_stall_req_o (f_stall_req_o)
   );

   // ---------------------------------------------------------------------
   // Scoreboard state and program memory
   // ---------------------------------------------------------------------
   logic [EXP_W-1:0] exp_q[$];
   int               n_tests = 0;
   int               n_fail  = 0;
   logic             valid_prev = 1'b0;
   logic [7:0]       mem [0:511];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [EXP_W-1:0] mk(input logic [3:0] icode, input logic [3:0] ifun,
                                           input logic [3:0] ra, input logic [3:0] rb,
                                           input logic [63:0] valc, input logic [63:0] valp,
                                           input logic [63:0] pred, input logic [1:0] stat);
      exp_t e;
      e.icode = icode;
      e.ifun  = ifun;
      e.ra    = ra;
      e.rb    = rb;
      e.valc  = valc;
      e.valp  = valp;
      e.pred  = pred;
      e.stat  = stat;
      return e;
   endfunction

   function automatic logic [WIN_W-1:0] win_at(input logic [63:0] a);
      logic [WIN_W-1:0] w;
      w = '0;
      for (int i = 0; i < WIN_BYTES; i++) begin
         w[8*i +: 8] = mem[(int'(a[8:0]) + i) % 512];
      end
      return w;
   endfunction

   // One clock: the bench plays the F register (takes f_predPC_o whenever the
   // stall request is low at the end of the cycle), then samples on the
   // falling edge and pops the scoreboard on each new f_valid_o.
   task automatic tick();
      exp_t e;
      #1;
      if (!f_stall_req_o) F_predPC_i = f_predPC_o;
      @(negedge clk_i);
      if (f_valid_o && !valid_prev) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 64'(f_valid_o), 64'd0);
         end else begin
            e = exp_t'(exp_q.pop_front());
            check("icode",  64'(f_icode_o),  64'(e.icode));
            check("ifun",   64'(f_ifun_o),   64'(e.ifun));
            check("rA",     64'(f_rA_o),     64'(e.ra));
            check("rB",     64'(f_rB_o),     64'(e.rb));
            check("valC",   f_valC_o,        e.valc);
            check("valP",   f_valP_o,        e.valp);
            check("predPC", f_predPC_o,      e.pred);
            check("stat",   64'(f_stat_o),   64'(e.stat));
         end
      end
      valid_prev = f_valid_o;
   endtask

   task automatic wait_req(input logic [63:0] exp_addr);
      int n;
      n = 0;
      tick();
      while (!imem_req_o && n < 50) begin
         tick();
         n++;
      end
      check("req_seen", 64'(imem_req_o), 64'd1);
      if (imem_req_o) check("req_addr", imem_addr_o, exp_addr);
   endtask

   task automatic respond(input logic [63:0] addr, input int wait_n, input logic err,
                          input logic [EXP_W-1:0] e);
      for (int i = 0; i < wait_n; i++) begin
         tick();
         check("req_held", 64'(imem_req_o), 64'd1);
      end
      imem_rdata_i = win_at(addr);
      imem_err_i   = err;
      imem_ack_i   = 1'b1;
      exp_q.push_back(e);
      tick();
      imem_ack_i   = 1'b0;
      imem_err_i   = 1'b0;
      imem_rdata_i = '0;
      check("valid_after_ack", 64'(f_valid_o), 64'd1);
      check("req_after_ack", 64'(imem_req_o), 64'd0);
   endtask

   task automatic expect_quiet(input int cycles);
      int reqs;
      reqs = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (imem_req_o) reqs++;
      end
      check("quiet_reqs", 64'(reqs), 64'd0);
      check("quiet_stall", 64'(f_stall_req_o), 64'd1);
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      rst_i        = 1'b1;
      F_predPC_i   = '0;
      M_icode_i    = 4'h0;
      M_Cnd_i      = 1'b0;
      M_valA_i     = '0;
      W_icode_i    = 4'h0;
      W_valM_i     = '0;
      D_stall_i    = 1'b0;
      imem_ack_i   = 1'b0;
      imem_rdata_i = '0;
      imem_err_i   = 1'b0;

      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      mem[9'h000] = 8'h30; mem[9'h001] = 8'hF2; mem[9'h002] = 8'h0A;  // irmovq $10,%rdx
      mem[9'h00A] = 8'h70; mem[9'h00B] = 8'h20;                       // jmp 0x20
      mem[9'h020] = 8'h70; mem[9'h021] = 8'h00; mem[9'h022] = 8'h01;  // jmp 0x100
      mem[9'h100] = 8'h60; mem[9'h101] = 8'h23;                       // addq %rdx,%rbx
      mem[9'h040] = 8'h30; mem[9'h041] = 8'hF2; mem[9'h042] = 8'h05;  // squashed
      mem[9'h060] = 8'hC0;                                            // illegal
      mem[9'h080] = 8'h30; mem[9'h081] = 8'hF2; mem[9'h082] = 8'h0A;  // bytes ignored on error
      mem[9'h090] = 8'h00;                                            // halt

      tick();
      tick();
      check("rst_req",    64'(imem_req_o),    64'd0);
      check("rst_valid",  64'(f_valid_o),     64'd0);
      check("rst_stat",   64'(f_stat_o),      64'(ST_AOK));
      check("rst_stall",  64'(f_stall_req_o), 64'd1);
      check("rst_icode",  64'(f_icode_o),     64'd0);
      check("rst_rB",     64'(f_rB_o),        64'd0);
      check("rst_valP",   f_valP_o,           64'd0);
      check("rst_predPC", f_predPC_o,         64'd0);
      rst_i = 1'b0;

      // Straight-line fetches with different memory latencies.
      wait_req(64'h0);
      respond(64'h0, 2, 1'b0, mk(4'h3, 4'h0, 4'hF, 4'h2, 64'hA, 64'hA, 64'hA, ST_AOK));
      wait_req(64'hA);
      respond(64'hA, 0, 1'b0, mk(4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'h13, 64'h20, ST_AOK));
      wait_req(64'h20);
      respond(64'h20, 1, 1'b0, mk(4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h29, 64'h100, ST_AOK));

      // Decode stall: instruction held, no new request.
      wait_req(64'h100);
      D_stall_i = 1'b1;
      respond(64'h100, 0, 1'b0, mk(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h102, 64'h102, ST_AOK));
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hold_valid", 64'(f_valid_o),     64'd1);
         check("hold_icode", 64'(f_icode_o),     64'h6);
         check("hold_rA",    64'(f_rA_o),        64'h2);
         check("hold_valP",  f_valP_o,           64'h102);
         check("hold_stall", 64'(f_stall_req_o), 64'd1);
         check("hold_req",   64'(imem_req_o),    64'd0);
      end
      D_stall_i = 1'b0;
      wait_req(64'h102);

      // Mispredicted jXX while the read is outstanding: drain, then refetch.
      M_icode_i = 4'h7;
      M_Cnd_i   = 1'b0;
      M_valA_i  = 64'h40;
      tick();
      M_icode_i = 4'h0;
      check("drain_req", 64'(imem_req_o), 64'd1);
      tick();
      tick();
      imem_rdata_i = win_at(64'h102);
      imem_ack_i   = 1'b1;
      tick();
      imem_ack_i   = 1'b0;
      check("drain_no_valid", 64'(f_valid_o),  64'd0);
      check("drain_req_drop", 64'(imem_req_o), 64'd0);
      wait_req(64'h40);

      // ret redirect in the same cycle as ack: data dropped.
      imem_rdata_i = win_at(64'h40);
      imem_ack_i   = 1'b1;
      W_icode_i    = 4'h9;
      W_valM_i     = 64'h60;
      tick();
      imem_ack_i   = 1'b0;
      W_icode_i    = 4'h0;
      check("redir_ack_no_valid", 64'(f_valid_o),  64'd0);
      check("redir_ack_req_drop", 64'(imem_req_o), 64'd0);
      wait_req(64'h60);

      // Illegal opcode stops fetching.
      respond(64'h60, 1, 1'b0, mk(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h61, 64'h61, ST_INS));
      expect_quiet(10);

      // Redirect restarts; address error stops again.
      W_icode_i = 4'h9;
      W_valM_i  = 64'h80;
      tick();
      W_icode_i = 4'h0;
      wait_req(64'h80);
      respond(64'h80, 0, 1'b1, mk(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h81, 64'h81, ST_ADR));
      expect_quiet(10);

      // Halt stops fetching too.
      W_icode_i = 4'h9;
      W_valM_i  = 64'h90;
      tick();
      W_icode_i = 4'h0;
      wait_req(64'h90);
      respond(64'h90, 0, 1'b0, mk(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h91, 64'h91, ST_HLT));
      expect_quiet(10);

      // Asynchronous reset while an instruction is held.
      W_icode_i = 4'h9;
      W_valM_i  = 64'h0;
      tick();
      W_icode_i = 4'h0;
      D_stall_i = 1'b1;
      wait_req(64'h0);
      respond(64'h0, 0, 1'b0, mk(4'h3, 4'h0, 4'hF, 4'h2, 64'hA, 64'hA, 64'hA, ST_AOK));
      #2;
      rst_i = 1'b1;
      #1;
      check("arst_hold_valid", 64'(f_valid_o), 64'd0);
      check("arst_hold_icode", 64'(f_icode_o), 64'd0);
      check("arst_hold_stat",  64'(f_stat_o),  64'(ST_AOK));
      D_stall_i  = 1'b0;
      F_predPC_i = '0;
      tick();
      rst_i = 1'b0;

      // Asynchronous reset mid-request, then a clean restart.
      wait_req(64'h0);
      #2;
      rst_i = 1'b1;
      #1;
      check("arst_req_drop",   64'(imem_req_o),    64'd0);
      check("arst_req_valid",  64'(f_valid_o),     64'd0);
      check("arst_req_stall",  64'(f_stall_req_o), 64'd1);
      F_predPC_i = '0;
      tick();
      rst_i = 1'b0;
      wait_req(64'h0);
      respond(64'h0, 1, 1'b0, mk(4'h3, 4'h0, 4'hF, 4'h2, 64'hA, 64'hA, 64'hA, ST_AOK));
      wait_req(64'hA);
      respond(64'hA, 0, 1'b0, mk(4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'h13, 64'h20, ST_AOK));
      tick();
      tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
